// File: rtl/charmap_tile_renderer_pkg.sv
// Shared geometry, address widths and glyph codes for the cassette overlay
// character-cell renderer and its RAMs.
package charmap_tile_renderer_pkg;

   localparam int CELL_W   = 8;
   localparam int CELL_H   = 8;
   localparam int MAP_COLS = 32;
   localparam int MAP_ROWS = 128;

   localparam int CHRAM_AW = 12;
   localparam int CHROM_AW = 11;

   localparam logic [7:0] GLYPH_BAR_FULL  = 8'h7F;
   localparam logic [7:0] GLYPH_BAR_EMPTY = 8'hA6;
   localparam logic [7:0] GEAR_A          = 8'h2A;
   localparam logic [7:0] GEAR_B          = 8'h96;

   // Font-byte bit that holds pixel column col of a glyph row.
   function automatic logic [2:0] pixel_sel(input logic msb_left, input logic [2:0] col);
      logic [2:0] sel;
      if (msb_left) begin
         sel = 3'd7 - col;
      end else begin
         sel = col;
      end
      return sel;
   endfunction

endpackage

// File: rtl/charmap_tile_renderer_tile_dpram.sv
// Generic dual-port RAM used for the overlay's character-index RAM and font ROM.
// Both ports have a registered read; the array has a single writer clocked by clock_a.
module tile_dpram #(
   parameter int widthad_a = 11,
   parameter int width_a   = 8,
   parameter     init_file = ""
) (
   input  logic                 clock_a,
   input  logic [widthad_a-1:0] address_a,
   input  logic                 wren_a,
   input  logic [width_a-1:0]   data_a,
   output logic [width_a-1:0]   q_a,
   input  logic                 clock_b,
   input  logic [widthad_a-1:0] address_b,
   input  logic                 wren_b,
   input  logic [width_a-1:0]   data_b,
   output logic [width_a-1:0]   q_b
);

   localparam int DEPTH = 1 << widthad_a;

   logic [width_a-1:0] mem_r [DEPTH];
   logic [width_a-1:0] q_a_r;
   logic [width_a-1:0] q_b_r;

   // Image preload comes from the vendor memory-init flow; plain simulation starts blank.
   if (init_file != "") begin : g_preload
   end

   // Both ports commit writes on clock_a (ports share one domain); port a wins a collision.
   always_ff @(posedge clock_a) begin
      if (wren_b) begin
         mem_r[address_b] <= data_b;
      end
      if (wren_a) begin
         mem_r[address_a] <= data_a;
      end
   end

   // Port a registered read.
   always_ff @(posedge clock_a) begin
      q_a_r <= mem_r[address_a];
   end

   // Port b registered read.
   always_ff @(posedge clock_b) begin
      q_b_r <= mem_r[address_b];
   end

   assign q_a = q_a_r;
   assign q_b = q_b_r;

endmodule

// File: rtl/charmap_tile_renderer.sv
// Three-edge streaming 8x8 character-cell renderer: counters -> index RAM ->
// font ROM -> 1-bit glyph alpha, one pixel per clock.
module charmap_tile_renderer
   import charmap_tile_renderer_pkg::*;
#(
   parameter bit MSB_LEFT = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [9:0]          hcnt,
   input  logic [9:0]          vcnt,
   output logic [CHRAM_AW-1:0] chram_addr,
   input  logic [7:0]          chmap_data_out,
   output logic [CHROM_AW:0]   chrom_addr,
   input  logic [7:0]          chrom_data_out,
   output logic                a
);

   logic [2:0] v1_r;
   logic [2:0] h1_r;
   logic [2:0] h2_r;
   logic       a_r;
   logic [2:0] bit_sel_s;
   logic       a_next_s;
   logic       unused_hcnt_s;

   // The map is 256 pixels wide, so the top horizontal bits never reach the RAM.
   assign unused_hcnt_s = ^hcnt[9:8];

   assign chram_addr = {vcnt[9:3], hcnt[7:3]};
   assign chrom_addr = {1'b0, chmap_data_out, v1_r};

   // Pick the glyph-row bit for the pixel column that reaches the font output now.
   always_comb begin
      bit_sel_s = pixel_sel(MSB_LEFT, h2_r);
      a_next_s  = chrom_data_out[bit_sel_s];
   end

   // Pipeline the in-cell row/column alongside the two RAM reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1_r <= 3'd0;
         h1_r <= 3'd0;
         h2_r <= 3'd0;
         a_r  <= 1'b0;
      end else begin
         v1_r <= vcnt[2:0];
         h1_r <= hcnt[2:0];
         h2_r <= h1_r;
         a_r  <= a_next_s;
      end
   end

   assign a = a_r;

endmodule

// File: tb/tb_charmap_tile_renderer.sv
// Directed bench: renderer plus index RAM and font ROM, checked against a
// pixel model built from the bench's own copy of both memories.
module tb_charmap_tile_renderer;
   import charmap_tile_renderer_pkg::*;

   localparam bit MSB_LEFT = 1'b1;

   logic        clk;
   logic        reset;
   logic [9:0]  hcnt;
   logic [9:0]  vcnt;
   logic [11:0] chram_addr;
   logic [7:0]  chmap_data_out;
   logic [11:0] chrom_addr;
   logic [7:0]  chrom_data_out;
   logic        a;

   logic        idx_wren_b;
   logic [11:0] idx_addr_b;
   logic [7:0]  idx_data_b;
   logic [7:0]  idx_q_b;
   logic        font_wren_b;
   logic [10:0] font_addr_b;
   logic [7:0]  font_data_b;
   logic [7:0]  font_q_b;

   logic [7:0]  idx_m  [4096];
   logic [7:0]  font_m [2048];

   int n_tests;
   int n_fail;

   typedef struct {
      logic [9:0]  h;
      logic [9:0]  v;
      logic [11:0] exp_addr;
      string       name;
   } addr_vec_t;

   addr_vec_t addr_vecs [6];

   charmap_tile_renderer #(.MSB_LEFT(MSB_LEFT)) dut (
      .clk            (clk),
      .reset          (reset),
      .hcnt           (hcnt),
      .vcnt           (vcnt),
      .chram_addr     (chram_addr),
      .chmap_data_out (chmap_data_out),
      .chrom_addr     (chrom_addr),
      .chrom_data_out (chrom_data_out),
      .a              (a)
   );

   tile_dpram #(.widthad_a(12), .width_a(8), .init_file("")) u_index (
      .clock_a   (clk),
      .address_a (chram_addr),
      .wren_a    (1'b0),
      .data_a    (8'h00),
      .q_a       (chmap_data_out),
      .clock_b   (clk),
      .address_b (idx_addr_b),
      .wren_b    (idx_wren_b),
      .data_b    (idx_data_b),
      .q_b       (idx_q_b)
   );

   tile_dpram #(.widthad_a(11), .width_a(8), .init_file("")) u_font (
      .clock_a   (clk),
      .address_a (chrom_addr[10:0]),
      .wren_a    (1'b0),
      .data_a    (8'h00),
      .q_a       (chrom_data_out),
      .clock_b   (clk),
      .address_b (font_addr_b),
      .wren_b    (font_wren_b),
      .data_b    (font_data_b),
      .q_b       (font_q_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic model_a(input logic [9:0] h, input logic [9:0] v);
      logic [11:0] ad;
      logic [7:0]  code;
      logic [7:0]  row;
      ad   = {v[9:3], h[7:3]};
      code = idx_m[ad];
      row  = font_m[{code, v[2:0]}];
      return MSB_LEFT ? row[3'd7 - h[2:0]] : row[h[2:0]];
   endfunction

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Streams n pixels along one line; a for pixel i appears 3 edges after it is driven.
   task automatic stream(input logic [9:0] h0, input logic [9:0] v, input int n,
                         input string name, input bit use_ref, input logic [7:0] ref_byte);
      logic exp_q [$];
      logic [9:0] h;
      logic exp_bit;
      logic e;
      for (int i = 0; i < n + 3; i++) begin
         @(negedge clk);
         if (i >= 3) begin
            e = exp_q.pop_front();
            check_val($sformatf("%s[%0d]", name, i - 3), {31'd0, a}, {31'd0, e});
         end
         h = h0 + i[9:0];
         hcnt = h;
         vcnt = v;
         if (i >= n) begin
            exp_bit = 1'b0;
         end else if (use_ref) begin
            exp_bit = ref_byte[3'd7 - i[2:0]];
         end else begin
            exp_bit = model_a(h, v);
         end
         exp_q.push_back(exp_bit);
      end
   endtask

   task automatic write_idx(input logic [11:0] ad, input logic [7:0] d);
      @(negedge clk);
      idx_wren_b = 1'b1;
      idx_addr_b = ad;
      idx_data_b = d;
      @(negedge clk);
      idx_wren_b = 1'b0;
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      reset       = 1'b1;
      hcnt        = 10'd0;
      vcnt        = 10'd0;
      idx_wren_b  = 1'b0;
      idx_addr_b  = 12'd0;
      idx_data_b  = 8'd0;
      font_wren_b = 1'b0;
      font_addr_b = 11'd0;
      font_data_b = 8'd0;

      addr_vecs[0] = '{h: 10'd0,    v: 10'd0,    exp_addr: 12'd0,    name: "addr_origin"};
      addr_vecs[1] = '{h: 10'd88,   v: 10'd80,   exp_addr: 12'd331,  name: "addr_r10c11"};
      addr_vecs[2] = '{h: 10'd160,  v: 10'd80,   exp_addr: 12'd340,  name: "addr_r10c20"};
      addr_vecs[3] = '{h: 10'd344,  v: 10'd80,   exp_addr: 12'd331,  name: "addr_wrap"};
      addr_vecs[4] = '{h: 10'd64,   v: 10'd35,   exp_addr: 12'd136,  name: "addr_r4c8"};
      addr_vecs[5] = '{h: 10'd1023, v: 10'd1023, exp_addr: 12'd4095, name: "addr_max"};

      for (int i = 0; i < 4096; i++) idx_m[i] = 8'(i * 7 + 3);
      for (int j = 0; j < 2048; j++) font_m[j] = 8'(j * 13 + (j >> 4)) ^ 8'h3C;
      idx_m[136] = GLYPH_BAR_FULL;
      idx_m[340] = GEAR_A;
      font_m[{GLYPH_BAR_FULL, 3'd3}] = 8'hA5;

      for (int i = 0; i < 4096; i++) begin
         @(negedge clk);
         idx_wren_b = 1'b1;
         idx_addr_b = 12'(i);
         idx_data_b = idx_m[i];
         if (i < 2048) begin
            font_wren_b = 1'b1;
            font_addr_b = 11'(i);
            font_data_b = font_m[i];
         end else begin
            font_wren_b = 1'b0;
         end
      end
      @(negedge clk);
      idx_wren_b  = 1'b0;
      font_wren_b = 1'b0;

      check_val("reset_a", {31'd0, a}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         hcnt = addr_vecs[i].h;
         vcnt = addr_vecs[i].v;
         #1;
         check_val(addr_vecs[i].name, {20'd0, chram_addr}, {20'd0, addr_vecs[i].exp_addr});
      end

      // Tile code 0x2A on cell row 5 gives font address 0x155 after one edge.
      @(negedge clk);
      hcnt = 10'd160;
      vcnt = 10'd85;
      @(posedge clk);
      #1;
      check_val("font_addr", {20'd0, chrom_addr}, 32'h155);

      stream(10'd64, 10'd35, 8, "glyph_a5", 1'b1, 8'hA5);
      stream(10'd0, 10'd0, 256, "sweep_row0", 1'b0, 8'h00);

      // Asynchronous reset mid-row, then recovery on the third edge.
      @(negedge clk);
      hcnt = 10'd64;
      vcnt = 10'd35;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_pre", {31'd0, a}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_val("rst_async", {31'd0, a}, 32'd0);
      @(posedge clk);
      #1;
      check_val("rst_hold", {31'd0, a}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_release", {31'd0, a}, 32'd1);

      stream(10'd160, 10'd82, 8, "live_old", 1'b0, 8'h00);
      write_idx(12'd340, GEAR_B);
      idx_m[340] = GEAR_B;
      stream(10'd160, 10'd82, 8, "live_new", 1'b1, font_m[{GEAR_B, 3'd2}]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
